dispatch: RTL

- Consumer end of the rename-queue interface. Each cycle it takes an in-order prefix of valid ren_bundle lanes and returns the per-lane `rename` pop mask.
- For each taken lane it allocates a ROB id and computes source-ready bits from a physical-register busy table.
- Results are registered into a one-entry-deep dispatch stage that feeds the ROB and issue queues. Sits between rename and issue.

---
 rtl/dispatch_if.sv | 42 ++++
 rtl/dispatch.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dispatch_if.sv
// Rename/dispatch bus: the op bundle and pop mask from rename, plus the dispatch-stage contents
// that feed the ROB and issue queues.
package dispatch_pkg;
  localparam int unsigned rwd     = 2;
  localparam int unsigned prnum   = 64;
  localparam int unsigned robsz   = 32;
  localparam int unsigned wbw     = 2;
  localparam int unsigned cwd     = 2;
  localparam int unsigned rob_idw = $clog2(robsz) + 1;
  localparam int unsigned preg_w  = $clog2(prnum);
  localparam int unsigned com_w   = $clog2(cwd) + 1;
  localparam int unsigned take_w  = $clog2(rwd) + 1;

  // Renamed op. opid[15] is the lane-valid bit. prda[1] is the destination that gets allocated.
  typedef struct packed {
    logic [15:0]             opid;
    logic [1:0][preg_w-1:0]  prsa;
    logic [1:0][preg_w-1:0]  prda;
  } ren_bundle_t;
endpackage

interface dispatch_if;
  import dispatch_pkg::*;

  ren_bundle_t [rwd-1:0]           ren_bundle;
  logic        [rwd-1:0]           rename;
  logic                            dis_stall;
  logic        [rwd-1:0]           dis_valid;
  ren_bundle_t [rwd-1:0]           dis_bundle;
  logic        [rwd-1:0][rob_idw-1:0] dis_robid;
  logic        [rwd-1:0][1:0]      dis_rdy;

  modport master (
    output ren_bundle, dis_stall,
    input  rename, dis_valid, dis_bundle, dis_robid, dis_rdy
  );

  modport slave (
    input  ren_bundle, dis_stall,
    output rename, dis_valid, dis_bundle, dis_robid, dis_rdy
  );
endinterface

// File: rtl/dispatch.sv
// Dispatch: takes an in-order prefix of renamed ops, allocates ROB ids, computes source-ready
// bits from the physical-register busy table and registers the group into a one-deep stage.
// Optional feature macro: DISPATCH_WB_BYPASS_EN (same-cycle writeback bypass into source-ready).
module dispatch
  import dispatch_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  dispatch_if.slave                    bus,
  input  logic                         red_valid,
  input  logic [rob_idw-1:0]           red_robid,
  input  logic [com_w-1:0]             com_num,
  input  logic [wbw-1:0]               wb_valid,
  input  logic [wbw-1:0][preg_w-1:0]   wb_preg
);

  logic [prnum-1:0]              busy;
  logic [rob_idw-1:0]            rob_tail;
  logic [rob_idw-1:0]            rob_cnt;

  logic [rob_idw-1:0]            rob_free_c;
  logic [rob_idw-1:0]            rob_head_c;
  logic                          accept_c;
  logic [rwd-1:0]                taken_c;
  logic [take_w-1:0]             take_n_c;
  logic [rwd-1:0][rob_idw-1:0]   robid_c;
  logic [rwd-1:0][1:0]           rdy_c;
  logic [prnum-1:0]              busy_n_c;
  logic [rwd-1:0][1:0]           held_rdy_c;

  // Lane selection: contiguous valid prefix, limited by free ROB entries.
  always_comb begin : take_sel
    logic prefix;
    rob_free_c = rob_idw'(robsz) - rob_cnt;
    rob_head_c = rob_tail - rob_cnt + rob_idw'(com_num);
    accept_c   = !red_valid && (!bus.dis_stall || !(|bus.dis_valid));
    prefix     = 1'b1;
    taken_c    = '0;
    take_n_c   = '0;
    robid_c    = '0;
    for (int i = 0; i < rwd; i++) begin
      prefix     = prefix & bus.ren_bundle[i].opid[15];
      taken_c[i] = accept_c && prefix && (rob_idw'(i) < rob_free_c);
      take_n_c   = take_n_c + take_w'(taken_c[i]);
      robid_c[i] = rob_tail + rob_idw'(i);
    end
  end

  assign bus.rename = taken_c;

  // Source-ready per lane/operand, with intra-group dependencies forcing not-ready.
  always_comb begin : src_rdy
    logic [preg_w-1:0] src;
    rdy_c = '0;
    src   = '0;
    for (int i = 0; i < rwd; i++) begin
      for (int j = 0; j < 2; j++) begin
        src         = bus.ren_bundle[i].prsa[j];
        rdy_c[i][j] = !busy[src];
`ifdef DISPATCH_WB_BYPASS_EN
        for (int k = 0; k < wbw; k++) begin
          if (wb_valid[k] && (wb_preg[k] == src)) rdy_c[i][j] = 1'b1;
        end
`endif
        for (int m = 0; m < i; m++) begin
          if (taken_c[m] && (src != '0) && (bus.ren_bundle[m].prda[1] == src)) rdy_c[i][j] = 1'b0;
        end
      end
    end
  end

  // Busy table next state: wakeups clear, new allocations set and win over a same-cycle wakeup.
  always_comb begin : busy_next
    busy_n_c = busy;
    for (int k = 0; k < wbw; k++) begin
      if (wb_valid[k]) busy_n_c[wb_preg[k]] = 1'b0;
    end
    for (int i = 0; i < rwd; i++) begin
      if (taken_c[i]) busy_n_c[bus.ren_bundle[i].prda[1]] = 1'b1;
    end
    busy_n_c[0] = 1'b0;
  end

  // Wakeup snoop for ops parked in the stage while downstream stalls.
  always_comb begin : held_wake
    held_rdy_c = bus.dis_rdy;
    for (int i = 0; i < rwd; i++) begin
      for (int j = 0; j < 2; j++) begin
        for (int k = 0; k < wbw; k++) begin
          if (bus.dis_valid[i] && wb_valid[k] && (wb_preg[k] == bus.dis_bundle[i].prsa[j]))
            held_rdy_c[i][j] = 1'b1;
        end
      end
    end
  end

  // ROB tail/occupancy tracking; a redirect rewinds the tail past the last surviving op.
  always_ff @(posedge clk or negedge rst) begin : rob_ptrs
    if (!rst) begin
      rob_tail <= '0;
      rob_cnt  <= '0;
    end else if (red_valid) begin
      rob_tail <= red_robid + rob_idw'(1);
      rob_cnt  <= red_robid + rob_idw'(1) - rob_head_c;
    end else begin
      rob_tail <= rob_tail + rob_idw'(take_n_c);
      rob_cnt  <= rob_cnt + rob_idw'(take_n_c) - rob_idw'(com_num);
    end
  end

  // Busy table register.
  always_ff @(posedge clk or negedge rst) begin : busy_reg
    if (!rst) busy <= '0;
    else      busy <= busy_n_c;
  end

  // One-deep dispatch stage: load taken lanes, hold under stall, otherwise drain.
  always_ff @(posedge clk or negedge rst) begin : dis_stage
    if (!rst) begin
      bus.dis_valid  <= '0;
      bus.dis_bundle <= '0;
      bus.dis_robid  <= '0;
      bus.dis_rdy    <= '0;
    end else if (red_valid) begin
      bus.dis_valid <= '0;
    end else if (|taken_c) begin
      for (int i = 0; i < rwd; i++) begin
        bus.dis_valid[i] <= taken_c[i];
        if (taken_c[i]) begin
          bus.dis_bundle[i] <= bus.ren_bundle[i];
          bus.dis_robid[i]  <= robid_c[i];
          bus.dis_rdy[i]    <= rdy_c[i];
        end
      end
    end else if (bus.dis_stall) begin
      bus.dis_rdy <= held_rdy_c;
    end else begin
      bus.dis_valid <= '0;
    end
  end

endmodule
